// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - command scheduler in front of the 4-bit counter
//
// Merges button press pulses and a host valid/ready command channel,
// arbitrates round-robin and issues one single-cycle one-hot command at a
// time, followed by CMD_GAP idle cycles. Also drives the counter clock
// enable from freeze and counts button presses lost to a full pending slot.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   btn_pulse[3:0] one-cycle presses: 0 INC, 1 DEC, 2 TOGGLE, 3 CLEAR
//   host_valid     host command valid
//   host_cmd[1:0]  host command index (same encoding as btn_pulse bits)
//   host_ready     host handshake ready (combinational)
//   freeze         halts the counter and blocks new grants
//   ctr_buttons    registered one-hot command pulse to the counter
//   ctr_ce         registered ~freeze to the counter
//   busy           command in flight or local command pending
//   drop_cnt       saturating count of dropped button presses
module counter_ctrl #(
  parameter int CMD_GAP = 2,
  parameter int DROP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        btn_pulse,
  input  logic              host_valid,
  input  logic [1:0]        host_cmd,
  output logic              host_ready,
  input  logic              freeze,
  output logic [3:0]        ctr_buttons,
  output logic              ctr_ce,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  localparam logic RR_LOCAL = 1'b0;
  localparam logic RR_HOST  = 1'b1;
  localparam logic [7:0] GAP_LAST = 8'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);

  state_t      state;
  logic [3:0]  pend;
  logic        rr;
  logic [7:0]  gap_cnt;

  logic        can_grant;
  logic        grant_host;
  logic        grant_local;
  logic [3:0]  local_onehot;
  logic [3:0]  host_onehot;
  logic [3:0]  grant_clr;
  logic [3:0]  drops;
  logic [3:0]  pend_next;
  logic [2:0]  drop_num;
  logic [DROP_W+2:0] drop_sum;
  logic [DROP_W-1:0] drop_next;

  always_comb begin
    can_grant   = (state == IDLE) && !freeze;
    host_ready  = !rst && can_grant && ((pend == 4'b0000) || (rr == RR_HOST));
    grant_host  = host_valid && host_ready;
    grant_local = can_grant && !grant_host && (pend != 4'b0000);
    host_onehot = 4'b0001 << host_cmd;

    // Lowest-index pending bit wins a local grant.
    local_onehot = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) local_onehot = 4'b0001 << i;
    end

    grant_clr = grant_local ? local_onehot : 4'b0000;
    // A press on a bit being granted this edge re-arms it instead of dropping.
    drops     = btn_pulse & pend & ~grant_clr;
    pend_next = (pend & ~grant_clr) | btn_pulse;

    drop_num = 3'd0;
    for (int i = 0; i < 4; i++) begin
      drop_num = drop_num + {2'b00, drops[i]};
    end

    drop_sum = {3'b000, drop_cnt} + {{DROP_W{1'b0}}, drop_num};
    if (drop_sum[DROP_W+2:DROP_W] != 3'b000) drop_next = {DROP_W{1'b1}};
    else                                     drop_next = drop_sum[DROP_W-1:0];

    busy = !rst && ((state != IDLE) || (pend != 4'b0000));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend        <= 4'b0000;
      rr          <= RR_LOCAL;
      gap_cnt     <= 8'd0;
      ctr_buttons <= 4'b0000;
      ctr_ce      <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      ctr_ce   <= ~freeze;
      pend     <= pend_next;
      drop_cnt <= drop_next;
      case (state)
        IDLE: begin
          if (grant_host) begin
            ctr_buttons <= host_onehot;
            rr          <= ~rr;
            state       <= ISSUE;
          end else if (grant_local) begin
            ctr_buttons <= local_onehot;
            rr          <= ~rr;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          ctr_buttons <= 4'b0000;
          if (CMD_GAP == 0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= GAP_LAST;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: begin
          ctr_buttons <= 4'b0000;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
